// File: rtl/rs_age_ordered.sv
// Out-of-order reservation station: CDB wakeup with dispatch bypass, single issue port.
// Define RS_AGE_ORDER_EN for oldest-first selection via an age matrix; otherwise lowest-index wins.
module rs_age_ordered #(
   parameter int NUM_SLOTS = 8,
   parameter int NUM_CDB   = 2,
   parameter int TAG_W     = 7,
   parameter int PAYLOAD_W = 32,
   localparam int IDX_W    = $clog2(NUM_SLOTS),
   localparam int OCC_W    = $clog2(NUM_SLOTS + 1)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     disp_valid,
   output logic                     disp_ready,
   input  logic [TAG_W-1:0]         disp_src1_tag,
   input  logic [TAG_W-1:0]         disp_src2_tag,
   input  logic                     disp_src1_rdy,
   input  logic                     disp_src2_rdy,
   input  logic [PAYLOAD_W-1:0]     disp_payload,
   input  logic [NUM_CDB-1:0]       cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
   output logic                     issue_valid,
   input  logic                     issue_ready,
   output logic [TAG_W-1:0]         issue_src1_tag,
   output logic [TAG_W-1:0]         issue_src2_tag,
   output logic [PAYLOAD_W-1:0]     issue_payload,
   output logic [OCC_W-1:0]         occupancy
);

   logic [NUM_SLOTS-1:0]                valid_q, valid_d;
   logic [NUM_SLOTS-1:0]                src1_rdy_q, src1_rdy_d;
   logic [NUM_SLOTS-1:0]                src2_rdy_q, src2_rdy_d;
   logic [NUM_SLOTS-1:0][TAG_W-1:0]     src1_tag_q, src1_tag_d;
   logic [NUM_SLOTS-1:0][TAG_W-1:0]     src2_tag_q, src2_tag_d;
   logic [NUM_SLOTS-1:0][PAYLOAD_W-1:0] payload_q, payload_d;

   logic [NUM_SLOTS-1:0] runnable, candidates;
   logic [IDX_W-1:0]     sel_idx, alloc_idx;
   logic                 disp_fire, issue_fire;

   function automatic logic cdb_hit(input logic [TAG_W-1:0]         tag,
                                    input logic [NUM_CDB-1:0]       vld,
                                    input logic [NUM_CDB*TAG_W-1:0] tags);
      logic hit;
      hit = 1'b0;
      for (int p = 0; p < NUM_CDB; p++)
         if (vld[p] && tags[p*TAG_W +: TAG_W] == tag) hit = 1'b1;
      return hit;
   endfunction

   assign runnable = valid_q & src1_rdy_q & src2_rdy_q;

`ifdef RS_AGE_ORDER_EN
   logic [NUM_SLOTS-1:0][NUM_SLOTS-1:0] age_q, age_d;
   logic [NUM_SLOTS-1:0]                older_rdy;

   // A runnable slot is blocked if any other runnable slot is older than it.
   always_comb begin
      older_rdy = '0;
      for (int i = 0; i < NUM_SLOTS; i++)
         for (int j = 0; j < NUM_SLOTS; j++)
            if (runnable[j] && age_q[j][i]) older_rdy[i] = 1'b1;
   end
   assign candidates = runnable & ~older_rdy;
`else
   assign candidates = runnable;
`endif

   always_comb begin
      sel_idx   = '0;
      alloc_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (candidates[i]) sel_idx   = IDX_W'(i);
         if (!valid_q[i])   alloc_idx = IDX_W'(i);
      end
   end

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < NUM_SLOTS; i++) occupancy = occupancy + OCC_W'(valid_q[i]);
   end

   assign disp_ready  = (~&valid_q) & ~flush;
   assign issue_valid = (|runnable) & ~flush;
   assign disp_fire   = disp_valid & disp_ready;
   assign issue_fire  = issue_valid & issue_ready;

   always_comb begin
      issue_src1_tag = '0;
      issue_src2_tag = '0;
      issue_payload  = '0;
      if (issue_valid) begin
         issue_src1_tag = src1_tag_q[sel_idx];
         issue_src2_tag = src2_tag_q[sel_idx];
         issue_payload  = payload_q[sel_idx];
      end
   end

   always_comb begin
      valid_d    = valid_q;
      src1_tag_d = src1_tag_q;
      src2_tag_d = src2_tag_q;
      payload_d  = payload_q;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         src1_rdy_d[i] = src1_rdy_q[i] | cdb_hit(src1_tag_q[i], cdb_valid, cdb_tag);
         src2_rdy_d[i] = src2_rdy_q[i] | cdb_hit(src2_tag_q[i], cdb_valid, cdb_tag);
      end
      if (issue_fire) valid_d[sel_idx] = 1'b0;
      // Dispatch bypass: a broadcast in the dispatch cycle is captured with the entry.
      if (disp_fire) begin
         valid_d[alloc_idx]    = 1'b1;
         src1_tag_d[alloc_idx] = disp_src1_tag;
         src2_tag_d[alloc_idx] = disp_src2_tag;
         payload_d[alloc_idx]  = disp_payload;
         src1_rdy_d[alloc_idx] = disp_src1_rdy | cdb_hit(disp_src1_tag, cdb_valid, cdb_tag);
         src2_rdy_d[alloc_idx] = disp_src2_rdy | cdb_hit(disp_src2_tag, cdb_valid, cdb_tag);
      end
      if (flush) valid_d = '0;
   end

`ifdef RS_AGE_ORDER_EN
   always_comb begin
      age_d = age_q;
      if (issue_fire) begin
         age_d[sel_idx] = '0;
         for (int j = 0; j < NUM_SLOTS; j++) age_d[j][sel_idx] = 1'b0;
      end
      // New entry is younger than every survivor; the issuing slot is already cleared.
      if (disp_fire) begin
         age_d[alloc_idx] = '0;
         for (int j = 0; j < NUM_SLOTS; j++)
            age_d[j][alloc_idx] = valid_q[j] & ~(issue_fire && sel_idx == IDX_W'(j));
      end
      if (flush) age_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) age_q <= '0;
      else          age_q <= age_d;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q    <= '0;
         src1_rdy_q <= '0;
         src2_rdy_q <= '0;
         src1_tag_q <= '0;
         src2_tag_q <= '0;
         payload_q  <= '0;
      end else begin
         valid_q    <= valid_d;
         src1_rdy_q <= src1_rdy_d;
         src2_rdy_q <= src2_rdy_d;
         src1_tag_q <= src1_tag_d;
         src2_tag_q <= src2_tag_d;
         payload_q  <= payload_d;
      end
   end

endmodule

// File: tb/tb_rs_age_ordered.sv
// Directed bench for rs_age_ordered: ordering, wakeup, bypass, full, flush and reset.
module tb_rs_age_ordered;
   localparam int NUM_SLOTS = 8;
   localparam int NUM_CDB   = 2;
   localparam int TAG_W     = 7;
   localparam int PAYLOAD_W = 32;
   localparam int OCC_W     = $clog2(NUM_SLOTS + 1);

   logic                     clk = 1'b0;
   logic                     reset_n, flush, disp_valid, disp_ready;
   logic [TAG_W-1:0]         disp_src1_tag, disp_src2_tag;
   logic                     disp_src1_rdy, disp_src2_rdy;
   logic [PAYLOAD_W-1:0]     disp_payload;
   logic [NUM_CDB-1:0]       cdb_valid;
   logic [NUM_CDB*TAG_W-1:0] cdb_tag;
   logic                     issue_valid, issue_ready;
   logic [TAG_W-1:0]         issue_src1_tag, issue_src2_tag;
   logic [PAYLOAD_W-1:0]     issue_payload;
   logic [OCC_W-1:0]         occupancy;

   int n_chk  = 0;
   int n_fail = 0;

   rs_age_ordered #(.NUM_SLOTS(NUM_SLOTS), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W),
                    .PAYLOAD_W(PAYLOAD_W)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
      .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
      .disp_payload(disp_payload), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_src1_tag(issue_src1_tag), .issue_src2_tag(issue_src2_tag),
      .issue_payload(issue_payload), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input logic [TAG_W-1:0] t1, input logic r1, input logic [TAG_W-1:0] t2,
                       input logic r2, input logic [PAYLOAD_W-1:0] pay);
      disp_valid    = 1'b1;
      disp_src1_tag = t1;
      disp_src1_rdy = r1;
      disp_src2_tag = t2;
      disp_src2_rdy = r2;
      disp_payload  = pay;
   endtask

   logic [PAYLOAD_W-1:0] exp_ord [3];

   initial begin
      reset_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0;
      disp_src1_tag = '0; disp_src2_tag = '0; disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
      disp_payload = '0; cdb_valid = '0; cdb_tag = '0;
      #1;
      chk("rst_issue_valid", issue_valid, 0);
      chk("rst_disp_ready", disp_ready, 1);
      chk("rst_occ", occupancy, 0);
      chk("rst_payload", issue_payload, 0);
      tick(); tick();
      reset_n = 1'b1;

      // In-order dispatch of three ready entries, then drain.
      disp(7'h01, 1, 7'h02, 1, 32'hA0);
      #1 chk("t1_pre_issue_valid", issue_valid, 0);
      tick();
      chk("t1_issue_valid_n1", issue_valid, 1);
      chk("t1_occ1", occupancy, 1);
      disp(7'h01, 1, 7'h02, 1, 32'hB0); tick();
      disp(7'h01, 1, 7'h02, 1, 32'hC0); tick();
      disp_valid = 1'b0;
      chk("t1_occ3", occupancy, 3);
      issue_ready = 1'b1;
      #1 chk("t1_pay0", issue_payload, 32'hA0);
      tick(); chk("t1_pay1", issue_payload, 32'hB0); chk("t1_occ2", occupancy, 2);
      tick(); chk("t1_pay2", issue_payload, 32'hC0); chk("t1_occ1b", occupancy, 1);
      tick(); chk("t1_occ0", occupancy, 0); chk("t1_idle", issue_valid, 0);
      chk("t1_idle_pay", issue_payload, 0);
      issue_ready = 1'b0;

      // Wakeup on CDB port 1 lets the waiting older entry issue right after.
      disp(7'h12, 0, 7'h03, 1, 32'h100); tick();
      disp(7'h04, 1, 7'h05, 1, 32'h101); tick();
      disp_valid = 1'b0;
      issue_ready = 1'b1;
      cdb_valid = 2'b10; cdb_tag = {7'h12, 7'h00};
      #1 chk("t2_first", issue_payload, 32'h101);
      tick();
      cdb_valid = '0;
      #1 chk("t2_woken_valid", issue_valid, 1);
      chk("t2_woken_pay", issue_payload, 32'h100);
      chk("t2_woken_tag", issue_src1_tag, 7'h12);
      tick(); chk("t2_empty", issue_valid, 0);
      issue_ready = 1'b0;

      // Fill all slots waiting on tag 0x05.
      for (int i = 0; i < NUM_SLOTS; i++) begin
         disp(7'h05, 0, 7'h06, 1, 32'h200 + i);
         tick();
      end
      disp_valid = 1'b0;
      chk("t3_full_ready", disp_ready, 0);
      chk("t3_full_occ", occupancy, 8);
      chk("t3_none_run", issue_valid, 0);
      cdb_valid = 2'b01; cdb_tag = {7'h00, 7'h05};
      tick();
      cdb_valid = '0;
      chk("t3_woken", issue_valid, 1);
      chk("t3_still_full", disp_ready, 0);
      issue_ready = 1'b1;
      #1 chk("t3_pay0", issue_payload, 32'h200);
      tick();
      chk("t3_ready_after", disp_ready, 1);
      chk("t3_occ7", occupancy, 7);
      for (int i = 1; i < NUM_SLOTS; i++) begin
         chk($sformatf("t3_pay%0d", i), issue_payload, 32'h200 + i);
         tick();
      end
      chk("t3_occ0", occupancy, 0);
      issue_ready = 1'b0;

      // Dispatch bypass: broadcast matches the source being dispatched.
      disp(7'h33, 0, 7'h07, 1, 32'h300);
      cdb_valid = 2'b01; cdb_tag = {7'h00, 7'h33};
      tick();
      disp_valid = 1'b0; cdb_valid = '0;
      chk("t4_bypass_valid", issue_valid, 1);
      chk("t4_bypass_pay", issue_payload, 32'h300);
      issue_ready = 1'b1; tick(); issue_ready = 1'b0;
      chk("t4_occ0", occupancy, 0);

      // Slot 0 refilled after slots 1,2 were allocated.
      disp(7'h01, 1, 7'h01, 1, 32'h400); tick();
      disp(7'h01, 1, 7'h01, 1, 32'h401); tick();
      disp(7'h01, 1, 7'h01, 1, 32'h402); tick();
      disp_valid = 1'b0;
      issue_ready = 1'b1;
      #1 chk("t5_first", issue_payload, 32'h400);
      tick();
      issue_ready = 1'b0;
      disp(7'h01, 1, 7'h01, 1, 32'h403); tick();
      disp_valid = 1'b0;
`ifdef RS_AGE_ORDER_EN
      exp_ord[0] = 32'h401; exp_ord[1] = 32'h402; exp_ord[2] = 32'h403;
`else
      exp_ord[0] = 32'h403; exp_ord[1] = 32'h401; exp_ord[2] = 32'h402;
`endif
      issue_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("t5_ord%0d", i), issue_payload, exp_ord[i]);
         tick();
      end
      chk("t5_occ0", occupancy, 0);
      issue_ready = 1'b0;

      // Flush with five entries while both handshakes are offered.
      for (int i = 0; i < 5; i++) begin
         disp(7'h01, 1, 7'h01, 1, 32'h500 + i);
         tick();
      end
      chk("t6_occ5", occupancy, 5);
      flush = 1'b1; issue_ready = 1'b1;
      disp(7'h01, 1, 7'h01, 1, 32'h5FF);
      #1 chk("t6_flush_dr", disp_ready, 0);
      chk("t6_flush_iv", issue_valid, 0);
      tick();
      flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0;
      #1 chk("t6_occ0", occupancy, 0);
      chk("t6_iv0", issue_valid, 0);

      // Asynchronous reset mid-stream.
      disp(7'h01, 1, 7'h01, 1, 32'h600); tick();
      disp(7'h01, 1, 7'h01, 1, 32'h601); tick();
      disp_valid = 1'b0;
      chk("t7_occ2", occupancy, 2);
      #2 reset_n = 1'b0;
      #1;
      chk("t7_rst_occ", occupancy, 0);
      chk("t7_rst_iv", issue_valid, 0);
      chk("t7_rst_pay", issue_payload, 0);
      chk("t7_rst_dr", disp_ready, 1);
      tick();
      reset_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/rs_age_ordered.md
# rs_age_ordered

Parametrised out-of-order reservation station with multi-port CDB wakeup, dispatch-cycle wakeup bypass, oldest-first issue and global flush. It sits between rename/dispatch and a single execution unit, holds up to NUM_SLOTS waiting instructions, and hands one runnable instruction per cycle to the unit over a valid/ready handshake.

## Interface
- NUM_SLOTS, 8: entry count, ≥2.
- NUM_CDB, 2: number of CDB broadcast ports, ≥1.
- TAG_W, 7: physical register tag width.
- PAYLOAD_W, 32: opaque instruction payload width (opcode, dest tag, ROB id, imm), carried unmodified.
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all entries (mispredict/exception).
- disp_valid  in  1  dispatch offers an instruction.
- disp_ready  out  1  a slot is free and flush is low.
- disp_src1_tag, disp_src2_tag  in  TAG_W each  source tags.
- disp_src1_rdy, disp_src2_rdy  in  1 each  source already available.
- disp_payload  in  PAYLOAD_W  instruction payload.
- cdb_valid  in  NUM_CDB  per-port broadcast valid.
- cdb_tag  in  NUM_CDB*TAG_W  per-port tag, port p at bits [p*TAG_W +: TAG_W].
- issue_valid  out  1  a runnable entry is presented.
- issue_ready  in  1  execution unit accepts.
- issue_src1_tag, issue_src2_tag  out  TAG_W each  tags of issued entry.
- issue_payload  out  PAYLOAD_W  payload of issued entry.
- occupancy  out  $clog2(NUM_SLOTS+1)  count of valid entries.

## Operation
- Per slot: valid, src1_rdy, src2_rdy, two tags, payload; age matrix age[i][j]=1 means slot i is older than slot j.
- Dispatch fire = disp_valid & disp_ready; writes the lowest-index free slot. New entry becomes younger than every currently valid entry: age[j][k]=1 for valid j, age[k][*]=0.
- disp_ready = (any slot invalid) & !flush; computed from current state only — a slot freed by same-cycle issue is not reusable until next cycle.
- Wakeup: a src ready bit sets when any port p has cdb_valid[p] and cdb_tag[p] equals that src tag. Multiple matching ports OR together. Applies to all valid slots and to the entry being dispatched (bypass): stored rdy = disp_srcN_rdy | any CDB match.
- Runnable = valid & src1_rdy & src2_rdy, from registered state.
- Selection: oldest runnable slot (no other runnable slot older). issue_* driven combinationally from the selected slot; all zero when issue_valid=0.
- issue_valid = any runnable & !flush; never depends on issue_ready. Issue fire = issue_valid & issue_ready clears the slot's valid bit and its age row/column.
- flush=1: all valid bits and age matrix cleared at the edge; no dispatch or issue fires that cycle.
- Simultaneous dispatch, issue and wakeup in one cycle are all honoured; wakeups targeting the issuing slot are harmless.
- occupancy = popcount(valid), combinational from registered state.

## Timing
- Reset (async assert, sync-safe deassert): all valid=0, age=0; issue_valid=0, issue_* =0, disp_ready=1, occupancy=0. Reset mid-operation drops every entry immediately.
- Dispatch at edge N: entry occupies slot from N+1; if both srcs ready (incl. bypass), issue_valid may assert in cycle N+1.
- CDB wakeup sampled at edge N: entry issuable in cycle N+1 (one-cycle wakeup-to-issue).
- Issue fire at edge N: occupancy decrements and slot is free in N+1.
- Full: disp_ready=0 while occupancy==NUM_SLOTS; dispatcher holds its inputs.

## Configuration
- RS_AGE_ORDER_EN defined: age matrix built, oldest-first selection as above.
- Undefined: no age matrix; selection picks the lowest-index runnable slot; all other behaviour identical.

## Test plan
- Reset then dispatch 3 entries with both srcs ready -> issue_valid from cycle after first dispatch, issued in dispatch order (slots 0,1,2), occupancy 1→3→0.
- Dispatch slot0 waiting on tag 0x12, slot1 ready; cdb_valid=2'b10, cdb_tag port1=0x12 -> slot1 issues first, slot0 issues the cycle after the broadcast.
- Fill 8 entries with src tag 0x05 unready -> disp_ready=0, occupancy=8; broadcast 0x05 with issue_ready=0 then 1 -> issue in age order, disp_ready=1 the cycle after first issue fires.
- Dispatch with disp_src1_rdy=0, tag 0x33, while cdb port0 broadcasts 0x33 same cycle -> entry stored ready, issue_valid next cycle.
- With RS_AGE_ORDER_EN: free slot 0 after slots 1,2 allocated, refill slot 0 -> slots issue 1,2,0; without macro -> 0,1,2.
- Flush with 5 valid entries and issue_ready=1, disp_valid=1 -> no fire, occupancy=0, issue_valid=0 next cycle; reset_n low mid-stream -> outputs at reset values immediately.
